// File: rtl/i2c_master_pkg.sv
// Shared I2C types and constants for the single-byte controller and its target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_MACK,
    ST_STOP
  } i2c_m_state_t;

  typedef logic [1:0] quarter_t;

  localparam logic       I2C_RD      = 1'b1;
  localparam logic       I2C_WR      = 1'b0;
  localparam logic [6:0] I2C_ADDRESS = 7'h49;

endpackage

// File: rtl/i2c_master_if.sv
// Command and pad bundle between the command source, i2c_master and the board pins.
interface i2c_master_if;
  import i2c_pkg::*;

  // Command handshake: go is a level request taken on any clock where the
  // controller is IDLE (busy=0); addr/r1w0/wdata are captured on that clock.
  // done pulses once at the end, with nack/rdata valid from that cycle on.
  logic         go;
  logic [6:0]   addr;
  logic         r1w0;
  logic [7:0]   wdata;
  logic [7:0]   rdata;
  logic         busy;
  logic         done;
  logic         nack;
  logic         SDA_in;
  logic         SDA_out;
  logic         SCL_out;
  i2c_m_state_t dbg_state;

  modport master (
    input  go, addr, r1w0, wdata, SDA_in,
    output rdata, busy, done, nack, SDA_out, SCL_out, dbg_state
  );

  modport slave (
    output go, addr, r1w0, wdata, SDA_in,
    input  rdata, busy, done, nack, SDA_out, SCL_out, dbg_state
  );

endinterface

// File: rtl/i2c_master_qtick.sv
// Quarter-period tick generator: one tick every CLK_DIV clocks while enabled.
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int            W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          cnt <= RELOAD;
    else if (restart)    cnt <= RELOAD;
    else if (en)         cnt <= (cnt == '0) ? RELOAD : cnt - W'(1);
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+R/W, one data byte, STOP, ACK status.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input logic         clock,
  input logic         reset,
  i2c_master_if.master bus
);

  i2c_m_state_t state, state_n;
  quarter_t     q, q_n;
  logic [2:0]   bitcnt, bitcnt_n;
  logic [7:0]   sh, sh_n;
  logic [7:0]   wd_q, wd_n;
  logic         rw_q, rw_n;
  logic         nack_q, nack_n;
  logic [7:0]   rdata_q, rdata_n;
  logic         done_q, done_n;
  logic         busy_q, busy_n;
  logic         sda_q, sda_n;
  logic         scl_q, scl_n;
  logic         tick, accept, at_sample, at_end;

  assign accept    = (state == ST_IDLE) && bus.go;
  assign at_sample = tick && (q == 2'd2);
  assign at_end    = tick && (q == 2'd3);

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clock   (clock),
    .reset   (reset),
    .restart (accept),
    .en      (state != ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      q       <= '0;
      bitcnt  <= '0;
      sh      <= '0;
      wd_q    <= '0;
      rw_q    <= I2C_WR;
      nack_q  <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sda_q   <= 1'b1;
      scl_q   <= 1'b1;
    end else begin
      state   <= state_n;
      q       <= q_n;
      bitcnt  <= bitcnt_n;
      sh      <= sh_n;
      wd_q    <= wd_n;
      rw_q    <= rw_n;
      nack_q  <= nack_n;
      rdata_q <= rdata_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      sda_q   <= sda_n;
      scl_q   <= scl_n;
    end
  end

  // One shift register serves both directions: it shifts out the address and
  // write byte, and shifts SDA in during a read.
  always_comb begin
    state_n  = state;
    q_n      = q;
    bitcnt_n = bitcnt;
    sh_n     = sh;
    wd_n     = wd_q;
    rw_n     = rw_q;
    nack_n   = nack_q;
    rdata_n  = rdata_q;
    done_n   = 1'b0;
    if (tick) q_n = q + 2'd1;
    case (state)
      ST_IDLE: begin
        if (bus.go) begin
          state_n  = ST_START;
          q_n      = '0;
          bitcnt_n = '0;
          sh_n     = {bus.addr, bus.r1w0};
          rw_n     = bus.r1w0;
          wd_n     = bus.wdata;
          nack_n   = 1'b0;
        end
      end
      ST_START: if (at_end) state_n = ST_ADDR;
      ST_ADDR, ST_WDATA: begin
        if (at_end) begin
          sh_n     = {sh[6:0], 1'b0};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = (state == ST_ADDR) ? ST_AACK : ST_WACK;
        end
      end
      ST_AACK: begin
        if (at_sample && bus.SDA_in) nack_n = 1'b1;
        if (at_end) begin
          if (nack_q)              state_n = ST_STOP;
          else if (rw_q == I2C_RD) state_n = ST_RDATA;
          else begin
            state_n = ST_WDATA;
            sh_n    = wd_q;
          end
        end
      end
      ST_WACK: begin
        if (at_sample && bus.SDA_in) nack_n = 1'b1;
        if (at_end) state_n = ST_STOP;
      end
      ST_RDATA: begin
        if (at_sample) sh_n = {sh[6:0], bus.SDA_in};
        if (at_end) begin
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = ST_MACK;
        end
      end
      ST_MACK: if (at_end) state_n = ST_STOP;
      ST_STOP: begin
        if (at_end) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          if ((rw_q == I2C_RD) && !nack_q) rdata_n = sh;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line levels are decoded from the next state so each quarter's levels
  // land in the register on the very tick that begins it.
  always_comb begin
    sda_n  = 1'b1;
    scl_n  = 1'b1;
    busy_n = (state_n != ST_IDLE);
    case (state_n)
      ST_IDLE: begin
        sda_n = 1'b1;
        scl_n = 1'b1;
      end
      ST_START: begin
        sda_n = 1'b0;
        scl_n = !q_n[1];
      end
      ST_STOP: begin
        sda_n = (q_n == 2'd3);
        scl_n = (q_n != 2'd0);
      end
      ST_ADDR, ST_WDATA: begin
        sda_n = sh_n[7];
        scl_n = ^q_n;
      end
      default: begin
        sda_n = 1'b1;
        scl_n = ^q_n;
      end
    endcase
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.nack      = nack_q;
  assign bus.SDA_out   = sda_q;
  assign bus.SCL_out   = scl_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural I2C target on a wired-AND SDA, vector table plus corner sequences.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  i2c_master_if bus ();
  logic tgt_sda = 1'b1;
  assign bus.SDA_in = bus.SDA_out & tgt_sda;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural target + bus monitor ----------------
  logic [7:0] tx_byte  = 8'h00;
  logic       ack_data = 1'b1;
  logic [7:0] rx_byte  = 8'h00;
  logic [7:0] mon_sh   = 8'h00;
  logic [7:0] seen_q[$];
  logic       ack_q[$];
  logic prev_scl = 1'b1, prev_sda = 1'b1, active = 1'b0, match = 1'b0, rd_bit = 1'b0;
  logic first_low = 1'b0, seen_rise = 1'b0;
  int bitn = 0, byte_idx = 0, run = 0, stop_cnt = 0, viol = 0;

  wire scl_l = bus.SCL_out;
  wire sda_l = bus.SDA_out & tgt_sda;

  always @(negedge clock) begin
    if (!reset) begin
      prev_scl = 1'b1; prev_sda = 1'b1; active = 1'b0; bitn = 0; byte_idx = 0;
      tgt_sda = 1'b1; first_low = 1'b0; seen_rise = 1'b0; run = 0;
    end else begin
      run++;
      if (scl_l && prev_scl && (sda_l != prev_sda)) begin
        if (!sda_l && !active) begin
          active = 1'b1; bitn = 0; byte_idx = 0; match = 1'b0; rd_bit = 1'b0;
          seen_q.delete(); ack_q.delete(); seen_rise = 1'b0; first_low = 1'b1;
        end else if (sda_l && active && byte_idx >= 1 && bitn <= 1) begin
          active = 1'b0;
          stop_cnt++;
        end else begin
          viol++;
        end
      end else if (scl_l && !prev_scl) begin
        if (!first_low) check("scl_low_time", run, 2 * CLK_DIV);
        first_low = 1'b0;
        seen_rise = 1'b1;
        run = 0;
        if (bitn < 8) mon_sh = {mon_sh[6:0], sda_l};
        else          ack_q.push_back(sda_l);
        bitn++;
        if (bitn == 8) seen_q.push_back(mon_sh);
      end else if (!scl_l && prev_scl) begin
        if (seen_rise) check("scl_high_time", run, 2 * CLK_DIV);
        run = 0;
        if (bitn == 9) begin
          bitn = 0;
          byte_idx++;
        end
        if (bitn == 8 && byte_idx == 0) begin
          match  = (mon_sh[7:1] == I2C_ADDRESS);
          rd_bit = mon_sh[0];
        end
        if (bitn == 8 && byte_idx == 1 && match && !rd_bit) rx_byte = mon_sh;
        tgt_sda = 1'b1;
        if (byte_idx == 0 && bitn == 8 && match)                        tgt_sda = 1'b0;
        else if (byte_idx == 1 && match && !rd_bit && bitn == 8)        tgt_sda = !ack_data;
        else if (byte_idx == 1 && match && rd_bit && bitn < 8)          tgt_sda = tx_byte[7 - bitn];
      end
      prev_scl = scl_l;
      prev_sda = sda_l;
    end
  end

  // ---------------- driver tasks ----------------
  int accept_cyc = 0;
  int stop_base  = 0;

  task automatic start_txn(input logic rw, input logic [6:0] a, input logic [7:0] d);
    stop_base  = stop_cnt;
    bus.go     = 1'b1;
    bus.addr   = a;
    bus.r1w0   = rw;
    bus.wdata  = d;
    @(posedge clock);
    #1;
    accept_cyc = cyc;
    bus.go     = 1'b0;
    bus.addr   = ~a;
    bus.r1w0   = ~rw;
    bus.wdata  = ~d;
  endtask

  // Latency is reported in the "cycle after edge" sense: accept edge t, done
  // registered at edge t+N and seen here as t+N+1.
  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = cyc - accept_cyc + 1;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] tx;
    logic       ack_data;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    logic       a0;
    logic       a1;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  task automatic check_txn(input string tag, input vec_t v);
    int lat;
    logic ok;
    logic [7:0] b;
    logic a;
    wait_done(lat, ok);
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " nack"}, 32'(bus.nack), 32'(v.exp_nack));
    check({tag, " rdata"}, 32'(bus.rdata), 32'(v.exp_rdata));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " stop_seen"}, stop_cnt, stop_base + 1);
    exp_q.delete();
    exp_q.push_back(v.b0);
    if (v.nbytes == 2) exp_q.push_back(v.b1);
    check({tag, " nbytes"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < v.nbytes; i++) begin
      b = (i < seen_q.size()) ? seen_q[i] : 8'h00;
      a = (i < ack_q.size()) ? ack_q[i] : 1'bx;
      check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp_q.pop_front()));
      check($sformatf("%s ack%0d", tag, i), 32'(a), 32'((i == 0) ? v.a0 : v.a1));
    end
    if (!v.rw && v.addr == I2C_ADDRESS)
      check({tag, " target_data_out"}, 32'(rx_byte), 32'(v.wdata));
  endtask

  vec_t vecs[6];
  vec_t v;

  // ---------------- test sequence ----------------
  initial begin
    bus.go = 1'b0; bus.addr = '0; bus.r1w0 = 1'b0; bus.wdata = '0;

    vecs[0] = '{1'b0, 7'h49, 8'hA5, 8'h00, 1'b1, 8'h92, 8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'h00, 321};
    vecs[1] = '{1'b1, 7'h49, 8'h00, 8'h3C, 1'b1, 8'h93, 8'h3C, 2, 1'b0, 1'b1, 1'b0, 8'h3C, 321};
    vecs[2] = '{1'b0, 7'h22, 8'h11, 8'h00, 1'b1, 8'h44, 8'h00, 1, 1'b1, 1'b0, 1'b1, 8'h3C, 177};
    vecs[3] = '{1'b0, 7'h49, 8'h5A, 8'h00, 1'b0, 8'h92, 8'h5A, 2, 1'b0, 1'b1, 1'b1, 8'h3C, 321};
    vecs[4] = '{1'b1, 7'h49, 8'hFF, 8'hC3, 1'b1, 8'h93, 8'hC3, 2, 1'b0, 1'b1, 1'b0, 8'hC3, 321};
    vecs[5] = '{1'b1, 7'h22, 8'h00, 8'h55, 1'b1, 8'h45, 8'h00, 1, 1'b1, 1'b0, 1'b1, 8'hC3, 177};

    repeat (3) @(posedge clock);
    #1;
    check("rst SDA_out", 32'(bus.SDA_out), 32'd1);
    check("rst SCL_out", 32'(bus.SCL_out), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst nack", 32'(bus.nack), 32'd0);
    check("rst rdata", 32'(bus.rdata), 32'd0);
    check("rst state", 32'(bus.dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++) begin
      tx_byte  = vecs[i].tx;
      ack_data = vecs[i].ack_data;
      start_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d busy_after_accept", i), 32'(bus.busy), 32'd1);
      check($sformatf("vec%0d start_sda", i), 32'(bus.SDA_out), 32'd0);
      check_txn($sformatf("vec%0d", i), vecs[i]);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d done_pulse", i), 32'(bus.done), 32'd0);
      repeat (5) @(posedge clock);
      #1;
    end

    // go pulsed mid-transaction must be ignored, then a back-to-back accept on done
    tx_byte  = 8'h00;
    ack_data = 1'b1;
    start_txn(1'b0, 7'h49, 8'hA5);
    repeat (100) @(posedge clock);
    #1;
    bus.go = 1'b1; bus.addr = 7'h10; bus.r1w0 = 1'b1; bus.wdata = 8'h00;
    @(posedge clock);
    #1;
    bus.go = 1'b0;
    check("overlap busy", 32'(bus.busy), 32'd1);
    v = '{1'b0, 7'h49, 8'hA5, 8'h00, 1'b1, 8'h92, 8'hA5, 2, 1'b0, 1'b0, 1'b0, 8'hC3, 321};
    check_txn("overlap", v);
    tx_byte = 8'h77;
    start_txn(1'b1, 7'h49, 8'h00);
    check("b2b busy", 32'(bus.busy), 32'd1);
    v = '{1'b1, 7'h49, 8'h00, 8'h77, 1'b1, 8'h93, 8'h77, 2, 1'b0, 1'b1, 1'b0, 8'h77, 321};
    check_txn("b2b", v);
    repeat (5) @(posedge clock);
    #1;

    // asynchronous reset during ADDR bit 3
    start_txn(1'b0, 7'h49, 8'hA5);
    repeat (69) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst SDA_out", 32'(bus.SDA_out), 32'd1);
    check("midrst SCL_out", 32'(bus.SCL_out), 32'd1);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("midrst done_held", 32'(bus.done), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    start_txn(1'b0, 7'h49, 8'h3E);
    v = '{1'b0, 7'h49, 8'h3E, 8'h00, 1'b1, 8'h92, 8'h3E, 2, 1'b0, 1'b0, 1'b0, 8'h00, 321};
    check_txn("after_rst", v);
    repeat (5) @(posedge clock);
    #1;

    check("bus_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C controller: the initiator end of the bus our `I2C_slave` responds on. On a `go` request it generates START, the 7-bit address plus R/W bit, and one data byte, either sent or received. It then generates STOP and reports completion with an ACK/NACK status. It drives the open-drain SDA/SCL pads through release/pull-low outputs and sits between an on-chip command source and the board I2C pins.

## Interface
- `CLK_DIV`, default 125: system clocks per SCL quarter-period. 100 kHz SCL at 50 MHz. Legal range ≥ 2.
- `clock` in 1: system clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low.
- `go` in 1: transaction request, accepted only in IDLE.
- `addr` in 7: target address, latched at accept.
- `r1w0` in 1: 1 = read a byte from target, 0 = write `wdata`; latched at accept.
- `wdata` in 8: write byte, latched at accept.
- `rdata` out 8: received byte, updated at `done` of a successful read, held otherwise.
- `busy` out 1: high from the cycle after accept through the STOP phase.
- `done` out 1: one-cycle pulse at transaction end.
- `nack` out 1: status, valid with `done` and held until the next accept.
- `SDA_in` in 1: sampled bus SDA.
- `SDA_out` out 1: 0 = pull SDA low, 1 = release.
- `SCL_out` out 1: 0 = pull SCL low, 1 = release. No clock stretching.

## Operation
- **Reset values:** `SDA_out`=1, `SCL_out`=1, `busy`=0, `done`=0, `nack`=0, `rdata`=0x00, state IDLE. Reset mid-transaction releases both lines immediately and asynchronously; there is no STOP and no `done`.
- **Timing base:** a quarter-tick counter produces one tick every `CLK_DIV` clocks while not IDLE. It restarts at accept.
- **Phases:** every phase spans 4 quarters, q0..q3.
- **START:** q0 SDA=0 with SCL=1; q1 hold; q2 SCL=0; q3 hold.
- **Bit phase:**
  - q0: SCL=0, SDA set to the bit (1 = release).
  - q1 and q2: SCL=1.
  - SDA_in is sampled on the tick that ends q2.
  - q3: SCL=0.
- **STOP:** q0 SCL=0, SDA=0; q1 SCL=1; q2 hold; q3 SDA=1.
- **State sequence:** IDLE → START → ADDR → AACK → (WDATA → WACK | RDATA → MACK) → STOP → IDLE.
  - ADDR sends {addr, r1w0}, MSB first, 8 bit phases.
  - AACK releases SDA and samples it. A sampled 1 sets `nack`=1 and jumps to STOP, skipping the data phase.
  - WDATA sends `wdata` MSB first. WACK samples SDA; a 1 sets `nack`=1. STOP follows either way.
  - RDATA releases SDA and shifts 8 samples in MSB first.
  - MACK: the master releases SDA (NACK, last byte), then STOP.
- **Bit counter:** 3-bit count of bit phases within a byte. It wraps at 7→0 on the byte's last bit.
- **Completion:** `done` pulses on the first IDLE cycle after STOP q3 ends; `busy`=0 on that same cycle. `go` is accepted on that cycle, so back-to-back transactions are allowed.
- `go` while `busy` is ignored, and input changes after accept have no effect.

## Timing
- All outputs are registered. The line levels of a quarter appear on the cycle after the tick that begins it.
- Accept at edge t:
  - `busy`=1 and `SDA_out`=0 (START q0) from t+1.
  - The first tick is at t+`CLK_DIV`.
- Full transaction (read or write): 20 phases = 80 ticks. `done` is at t+80·`CLK_DIV`+1.
- Address NACK: 11 phases. `done` is at t+44·`CLK_DIV`+1.
- SDA changes only while SCL=0, except the START and STOP edges.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_m_state_t`.
  - quarter typedef (2 bits).
  - constants `I2C_RD`=1 and `I2C_WR`=0.
  - default `I2C_ADDRESS`=7'h49, shared with `I2C_slave`.
- Sub-module `i2c_qtick`: parameterized down-counter producing the quarter tick, with synchronous restart.
- Top FSM, shift register and bit counter live in `i2c_master`.

## Test plan
Run with `CLK_DIV`=4, using a bus model (wired-AND) against `I2C_slave` at 0x49 or a behavioural target.
- **Write:** `go`, addr=0x49, r1w0=0, wdata=0xA5, target ACKs → SDA bit sequence 0x92, then 0xA5. `nack`=0, `done` at accept+321 cycles. Slave `data_out`=0xA5.
- **Read:** addr=0x49, r1w0=1, target returns 0x3C → `rdata`=0x3C, 9th data bit released (SDA=1), STOP seen, `nack`=0.
- **Address NACK:** addr=0x22, no target ACK → no data phase, `done` at accept+177 cycles, `nack`=1, `rdata` unchanged.
- **Overlapping requests:** `go` pulsed mid-transaction with addr=0x10 → ignored, transaction completes with the original fields. A second `go` on the `done` cycle is accepted, and `busy` stays 1 on the next cycle.
- **Reset mid-transaction:** reset asserted during ADDR bit 3 → `SDA_out`=`SCL_out`=1 and `busy`=0 immediately, no `done`. After release, a write to 0x49 completes normally.
- **Bus legality:** monitor checks across all runs that SDA never changes while SCL=1, except START and STOP. SCL high and low durations are both 2·`CLK_DIV`.
